// File: rtl/game_pkg.sv
// Shared encodings and default parameters for the match controller.
// Pure declarations: no logic, no latency, no flow control.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_SERVE_WAIT = 2'd2,
    ST_OVER       = 2'd3
  } state_e;

  localparam int DEF_NUM_PLAYERS = 2;
  localparam int DEF_SCORE_W     = 3;
  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_TICKS = 2;
  localparam int DEF_AUTO_SERVE  = 0;

  // Serve delay never exceeds 255 ticks.
  localparam int DELAY_W = 8;

endpackage

// File: rtl/serve_delay_counter.sv
// Serve delay: load to SERVE_TICKS, count down on tick, saturate at zero.
// zero_o is a decode of the registered count; no backpressure.
module serve_delay_counter
  import game_pkg::*;
#(
  parameter int SERVE_TICKS = DEF_SERVE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic tick_i,
  output logic zero_o
);

  logic [DELAY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = DELAY_W'(SERVE_TICKS);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/game_match_fsm.sv
// Match controller: scoring, serve delay, time-up and winner/draw resolution.
// All outputs registered; a miss at edge n is reflected right after edge n.
module game_match_fsm
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int AUTO_SERVE  = DEF_AUTO_SERVE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           tick,
  input  logic                           time_up,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                     state,
  output logic                           stop,
  output logic                           serve,
  output logic                           game_over,
  output logic [1:0]                     winner,
  output logic                           draw
);

  localparam int                 SCW       = NUM_PLAYERS * SCORE_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [SCW-1:0]   scores_q, scores_d;
  logic             serve_q, serve_d;
  logic             stop_q;
  logic             game_over_q;
  logic [1:0]       winner_q, winner_d;
  logic             draw_q, draw_d;
  logic             start_q;

  logic             start_edge;
  logic             ld_delay;
  logic             tick_en;
  logic             delay_zero;
  logic             enter_over;
  logic [SCW-1:0]   score_upd;
  logic [NUM_PLAYERS-1:0] win_hit;
  logic [1:0]       rank_idx;
  logic             rank_tie;

  assign start_edge = start & ~start_q;
  assign tick_en    = tick & (state_q == ST_SERVE_WAIT);

  serve_delay_counter #(
    .SERVE_TICKS (SERVE_TICKS)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld_delay),
    .tick_i (tick_en),
    .zero_o (delay_zero)
  );

  // Players that did not miss gain a point, saturating at the field maximum.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    logic [SCORE_W-1:0] cur;
    logic [SCORE_W-1:0] upd;
    assign cur = scores_q[p*SCORE_W +: SCORE_W];
    assign upd = (!miss[p] && (cur != SCORE_MAX)) ? cur + SCORE_W'(1) : cur;
    assign score_upd[p*SCORE_W +: SCORE_W] = upd;
    assign win_hit[p] = (upd >= WIN_V);
  end

  // Running maximum over the scores being committed; strict '>' keeps the lowest index.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_rank
    logic [SCORE_W-1:0] sc;
    logic [SCORE_W-1:0] bv;
    logic [1:0]         bi;
    logic               tie;
    assign sc = scores_d[p*SCORE_W +: SCORE_W];
    if (p == 0) begin : g_base
      assign bv  = sc;
      assign bi  = 2'd0;
      assign tie = 1'b0;
    end else begin : g_link
      assign bv  = (sc > g_rank[p-1].bv) ? sc : g_rank[p-1].bv;
      assign bi  = (sc > g_rank[p-1].bv) ? 2'(p) : g_rank[p-1].bi;
      assign tie = (sc > g_rank[p-1].bv) ? 1'b0
                                         : ((sc == g_rank[p-1].bv) || g_rank[p-1].tie);
    end
  end

  assign rank_idx = g_rank[NUM_PLAYERS-1].bi;
  assign rank_tie = g_rank[NUM_PLAYERS-1].tie;

  always_comb begin
    state_d  = state_q;
    scores_d = scores_q;
    serve_d  = 1'b0;
    ld_delay = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          scores_d = '0;
          state_d  = ST_PLAY;
          serve_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        // time_up wins over any miss arriving in the same cycle.
        if (time_up) begin
          state_d = ST_OVER;
        end else if (|miss) begin
          scores_d = score_upd;
          if (|win_hit) begin
            state_d = ST_OVER;
          end else begin
            state_d  = ST_SERVE_WAIT;
            ld_delay = 1'b1;
          end
        end
      end
      ST_SERVE_WAIT: begin
        if (time_up) begin
          state_d = ST_OVER;
        end else if (delay_zero && ((AUTO_SERVE != 0) || start_edge)) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enter_over = (state_d == ST_OVER) && (state_q != ST_OVER);
  assign winner_d   = enter_over ? rank_idx : winner_q;
  assign draw_d     = enter_over ? rank_tie : draw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scores_q    <= '0;
      serve_q     <= 1'b0;
      stop_q      <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 2'd0;
      draw_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      scores_q    <= scores_d;
      serve_q     <= serve_d;
      stop_q      <= (state_d != ST_PLAY);
      game_over_q <= (state_d == ST_OVER);
      winner_q    <= winner_d;
      draw_q      <= draw_d;
      start_q     <= start;
    end
  end

  assign scores    = scores_q;
  assign state     = state_q;
  assign stop      = stop_q;
  assign serve     = serve_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_game_match_fsm.sv
// Bench: directed match scenarios plus random play on a 2-player and a 4-player instance,
// both checked against a cycle-level rules model.
module tb_game_match_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st_a, tk_a, tu_a;
  logic [1:0] ms_a;
  logic [5:0] sc_a;
  logic [1:0] state_a, win_a;
  logic stop_a, serve_a, go_a, draw_a;

  logic st_b, tk_b, tu_b;
  logic [3:0] ms_b;
  logic [11:0] sc_b;
  logic [1:0] state_b, win_b;
  logic stop_b, serve_b, go_b, draw_b;

  int n_checks = 0;
  int n_errors = 0;

  game_match_fsm #(
    .NUM_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(3), .SERVE_TICKS(2), .AUTO_SERVE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(st_a), .tick(tk_a), .time_up(tu_a), .miss(ms_a),
    .scores(sc_a), .state(state_a), .stop(stop_a), .serve(serve_a),
    .game_over(go_a), .winner(win_a), .draw(draw_a)
  );

  game_match_fsm #(
    .NUM_PLAYERS(4), .SCORE_W(3), .WIN_SCORE(7), .SERVE_TICKS(1), .AUTO_SERVE(1)
  ) dut4 (
    .clk(clk), .rst(rst), .start(st_b), .tick(tk_b), .time_up(tu_b), .miss(ms_b),
    .scores(sc_b), .state(state_b), .stop(stop_b), .serve(serve_b),
    .game_over(go_b), .winner(win_b), .draw(draw_b)
  );

  // Rules model: index 0 is the 2-player instance, index 1 the 4-player one.
  int p_np[2]    = '{2, 4};
  int p_win[2]   = '{3, 7};
  int p_ticks[2] = '{2, 1};
  int p_auto[2]  = '{0, 1};
  int m_state[2];
  int m_cnt[2];
  int m_winner[2];
  int m_sc[2][4];
  bit m_prev[2];
  bit m_serve[2];
  bit m_draw[2];

  function automatic int exp_scores(int k);
    int r = 0;
    for (int p = 0; p < p_np[k]; p++) r = r | (m_sc[k][p] << (3 * p));
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_winner[k] = 0;
      m_prev[k] = 0; m_serve[k] = 0; m_draw[k] = 0;
      for (int p = 0; p < 4; p++) m_sc[k][p] = 0;
    end
  endtask

  task automatic enter_over(int k);
    int best = -1;
    int cnt = 0;
    m_state[k] = 3;
    for (int p = 0; p < p_np[k]; p++) begin
      if (m_sc[k][p] > best) begin best = m_sc[k][p]; m_winner[k] = p; end
    end
    for (int p = 0; p < p_np[k]; p++) if (m_sc[k][p] == best) cnt++;
    m_draw[k] = (cnt >= 2);
  endtask

  task automatic model_step(int k, bit st, bit tk, bit tu, int ms);
    bit edge_s;
    bit hit;
    edge_s = st && !m_prev[k];
    m_prev[k] = st;
    m_serve[k] = 0;
    case (m_state[k])
      0: if (edge_s) begin
           for (int p = 0; p < 4; p++) m_sc[k][p] = 0;
           m_state[k] = 1; m_serve[k] = 1;
         end
      1: if (tu) enter_over(k);
         else if (ms != 0) begin
           hit = 0;
           for (int p = 0; p < p_np[k]; p++) begin
             if (((ms >> p) & 1) == 0 && m_sc[k][p] < 7) m_sc[k][p]++;
             if (m_sc[k][p] >= p_win[k]) hit = 1;
           end
           if (hit) enter_over(k);
           else begin m_state[k] = 2; m_cnt[k] = p_ticks[k]; end
         end
      2: begin
           if (tu) enter_over(k);
           else if (m_cnt[k] == 0 && (p_auto[k] != 0 || edge_s)) begin
             m_state[k] = 1; m_serve[k] = 1;
           end
           if (tk && m_cnt[k] > 0) m_cnt[k]--;
         end
      default: if (edge_s) m_state[k] = 0;
    endcase
  endtask

  task automatic clk_step();
    model_step(0, st_a, tk_a, tu_a, int'(ms_a));
    model_step(1, st_b, tk_b, tu_b, int'(ms_b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic serve_back_a();
    tk_a = 1;
    for (int i = 0; i < p_ticks[0]; i++) clk_step();
    tk_a = 0; st_a = 1;
    clk_step();
    st_a = 0;
    clk_step();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (state_a !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state_a); end
    n_checks++; if (sc_a !== 6'd0) begin n_errors++; $display("FAIL reset_scores got=%0h exp=0", sc_a); end
    n_checks++; if (stop_a !== 1'b1) begin n_errors++; $display("FAIL reset_stop got=%0b exp=1", stop_a); end
    n_checks++; if ({serve_a, go_a, win_a, draw_a} !== 5'd0) begin n_errors++; $display("FAIL reset_flags got=%0b exp=0", {serve_a, go_a, win_a, draw_a}); end
    n_checks++; if (state_b !== 2'd0 || sc_b !== 12'd0) begin n_errors++; $display("FAIL reset_b got=%0d/%0h exp=0/0", state_b, sc_b); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_start();
    st_a = 1; clk_step(); st_a = 0;
    n_checks++; if (state_a !== 2'd1) begin n_errors++; $display("FAIL start_state got=%0d exp=1", state_a); end
    n_checks++; if (serve_a !== 1'b1) begin n_errors++; $display("FAIL start_serve got=%0b exp=1", serve_a); end
    n_checks++; if (sc_a !== 6'd0) begin n_errors++; $display("FAIL start_scores got=%0h exp=0", sc_a); end
    n_checks++; if (stop_a !== 1'b0) begin n_errors++; $display("FAIL start_stop got=%0b exp=0", stop_a); end
    clk_step();
    n_checks++; if (serve_a !== 1'b0) begin n_errors++; $display("FAIL start_serve_single got=%0b exp=0", serve_a); end
  endtask

  task automatic test_serve_delay();
    ms_a = 2'b01; clk_step(); ms_a = 0;
    n_checks++; if (sc_a !== 6'b001_000) begin n_errors++; $display("FAIL sd_scores got=%0h exp=%0h", sc_a, 6'b001_000); end
    n_checks++; if (state_a !== 2'd2 || stop_a !== 1'b1) begin n_errors++; $display("FAIL sd_state got=%0d/%0b exp=2/1", state_a, stop_a); end
    tk_a = 1; clk_step(); tk_a = 0;
    st_a = 1; clk_step(); st_a = 0;
    n_checks++; if (state_a !== 2'd2 || serve_a !== 1'b0) begin n_errors++; $display("FAIL sd_early_start got=%0d/%0b exp=2/0", state_a, serve_a); end
    tk_a = 1; clk_step(); tk_a = 0;
    n_checks++; if (state_a !== 2'd2) begin n_errors++; $display("FAIL sd_wait_edge got=%0d exp=2", state_a); end
    st_a = 1; clk_step(); st_a = 0;
    n_checks++; if (state_a !== 2'd1 || serve_a !== 1'b1) begin n_errors++; $display("FAIL sd_serve got=%0d/%0b exp=1/1", state_a, serve_a); end
    clk_step();
    n_checks++; if (serve_a !== 1'b0) begin n_errors++; $display("FAIL sd_serve_single got=%0b exp=0", serve_a); end
  endtask

  task automatic test_win();
    for (int i = 0; i < 3; i++) begin
      ms_a = 2'b10; clk_step(); ms_a = 0;
      if (i < 2) begin
        n_checks++; if (state_a !== 2'd2) begin n_errors++; $display("FAIL win_mid_state%0d got=%0d exp=2", i, state_a); end
        serve_back_a();
      end
    end
    n_checks++; if (state_a !== 2'd3 || go_a !== 1'b1) begin n_errors++; $display("FAIL win_over got=%0d/%0b exp=3/1", state_a, go_a); end
    n_checks++; if (sc_a[2:0] !== 3'd3 || sc_a !== 6'(exp_scores(0))) begin n_errors++; $display("FAIL win_scores got=%0h exp=%0h", sc_a, exp_scores(0)); end
    n_checks++; if (win_a !== 2'd0 || draw_a !== 1'b0) begin n_errors++; $display("FAIL win_winner got=%0d/%0b exp=0/0", win_a, draw_a); end
    clk_step();
    n_checks++; if (state_a !== 2'd3 || sc_a !== 6'b001_011) begin n_errors++; $display("FAIL win_hold got=%0d/%0h exp=3/b", state_a, sc_a); end
  endtask

  task automatic test_timeup_draw();
    st_a = 1; clk_step(); st_a = 0; clk_step();
    n_checks++; if (state_a !== 2'd0 || sc_a !== 6'(exp_scores(0))) begin n_errors++; $display("FAIL idle_hold got=%0d/%0h exp=0/%0h", state_a, sc_a, exp_scores(0)); end
    st_a = 1; clk_step(); st_a = 0; clk_step();
    ms_a = 2'b01; clk_step(); ms_a = 0; serve_back_a();
    ms_a = 2'b10; clk_step(); ms_a = 0; serve_back_a();
    tu_a = 1; ms_a = 2'b01; clk_step(); tu_a = 0; ms_a = 0;
    n_checks++; if (state_a !== 2'd3) begin n_errors++; $display("FAIL tu_state got=%0d exp=3", state_a); end
    n_checks++; if (sc_a !== 6'b001_001) begin n_errors++; $display("FAIL tu_scores got=%0h exp=9", sc_a); end
    n_checks++; if (draw_a !== 1'b1 || win_a !== 2'd0) begin n_errors++; $display("FAIL tu_draw got=%0b/%0d exp=1/0", draw_a, win_a); end
  endtask

  task automatic test_all_miss();
    st_a = 1; clk_step(); st_a = 0; clk_step();
    st_a = 1; clk_step(); st_a = 0; clk_step();
    ms_a = 2'b11; clk_step(); ms_a = 0;
    n_checks++; if (sc_a !== 6'd0 || state_a !== 2'd2) begin n_errors++; $display("FAIL all_miss got=%0h/%0d exp=0/2", sc_a, state_a); end
  endtask

  task automatic test_reset_mid();
    ms_a = 2'b01; tk_a = 1; clk_step(); ms_a = 0; clk_step(); tk_a = 0;
    rst = 1;
    #1;
    n_checks++; if (state_a !== 2'd0 || sc_a !== 6'd0 || stop_a !== 1'b1) begin n_errors++; $display("FAIL rst_mid got=%0d/%0h/%0b exp=0/0/1", state_a, sc_a, stop_a); end
    @(negedge clk); rst = 0; model_reset();
    st_a = 1; clk_step(); st_a = 0;
    n_checks++; if (state_a !== 2'd1 || serve_a !== 1'b1) begin n_errors++; $display("FAIL rst_restart got=%0d/%0b exp=1/1", state_a, serve_a); end
  endtask

  task automatic test_four();
    st_b = 1; clk_step(); st_b = 0;
    n_checks++; if (state_b !== 2'd1) begin n_errors++; $display("FAIL four_start got=%0d exp=1", state_b); end
    ms_b = 4'b0100; clk_step(); ms_b = 0;
    n_checks++; if (sc_b !== 12'o1011 || sc_b !== 12'(exp_scores(1))) begin n_errors++; $display("FAIL four_scores got=%0h exp=%0h", sc_b, 12'o1011); end
    n_checks++; if (state_b !== 2'd2) begin n_errors++; $display("FAIL four_sw got=%0d exp=2", state_b); end
    tk_b = 1; clk_step(); tk_b = 0; clk_step();
    n_checks++; if (state_b !== 2'd1 || serve_b !== 1'b1) begin n_errors++; $display("FAIL four_auto got=%0d/%0b exp=1/1", state_b, serve_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1; @(negedge clk); rst = 0; model_reset();
      end
      st_a = ($urandom_range(0, 3) == 0); tk_a = ($urandom_range(0, 2) == 0);
      tu_a = ($urandom_range(0, 49) == 0);
      ms_a = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
      st_b = ($urandom_range(0, 5) == 0); tk_b = ($urandom_range(0, 2) == 0);
      tu_b = ($urandom_range(0, 79) == 0);
      ms_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      clk_step();
      n_checks++; if (state_a !== 2'(m_state[0]) || sc_a !== 6'(exp_scores(0))) begin n_errors++; $display("FAIL rnd_a_core cyc=%0d got=%0d/%0h exp=%0d/%0h", i, state_a, sc_a, m_state[0], exp_scores(0)); end
      n_checks++; if ({stop_a, serve_a, go_a} !== {m_state[0] != 1, m_serve[0], m_state[0] == 3}) begin n_errors++; $display("FAIL rnd_a_flags cyc=%0d got=%0b exp=%0b", i, {stop_a, serve_a, go_a}, {m_state[0] != 1, m_serve[0], m_state[0] == 3}); end
      if (m_state[0] == 3) begin
        n_checks++; if (win_a !== 2'(m_winner[0]) || draw_a !== m_draw[0]) begin n_errors++; $display("FAIL rnd_a_result cyc=%0d got=%0d/%0b exp=%0d/%0b", i, win_a, draw_a, m_winner[0], m_draw[0]); end
      end
      n_checks++; if (state_b !== 2'(m_state[1]) || sc_b !== 12'(exp_scores(1))) begin n_errors++; $display("FAIL rnd_b_core cyc=%0d got=%0d/%0h exp=%0d/%0h", i, state_b, sc_b, m_state[1], exp_scores(1)); end
      n_checks++; if ({stop_b, serve_b, go_b} !== {m_state[1] != 1, m_serve[1], m_state[1] == 3}) begin n_errors++; $display("FAIL rnd_b_flags cyc=%0d got=%0b exp=%0b", i, {stop_b, serve_b, go_b}, {m_state[1] != 1, m_serve[1], m_state[1] == 3}); end
      if (m_state[1] == 3) begin
        n_checks++; if (win_b !== 2'(m_winner[1]) || draw_b !== m_draw[1]) begin n_errors++; $display("FAIL rnd_b_result cyc=%0d got=%0d/%0b exp=%0d/%0b", i, win_b, draw_b, m_winner[1], m_draw[1]); end
      end
    end
  endtask

  initial begin
    rst = 1;
    st_a = 0; tk_a = 0; tu_a = 0; ms_a = 0;
    st_b = 0; tk_b = 0; tu_b = 0; ms_b = 0;
    model_reset();
    test_reset();
    test_start();
    test_serve_delay();
    test_win();
    test_timeup_draw();
    test_all_miss();
    test_reset_mid();
    test_four();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
